// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two requesters and the register-file
// write arbiter. The requester side drives req/addr/data and sees the
// grants plus the registered write bus. The arbiter side is the reverse.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  grant_a;
  logic                  req_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  grant_b;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  grant_a, grant_b, busy, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    output grant_a, grant_b, busy, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single write port sequencer for the register file. After reset it
// clears every entry with zero, then shares the port between requesters
// A and B using round-robin arbitration. Writes aimed at the top address
// (the hardwired zero register) are consumed but never issued.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  regfile_write_arbiter_if.slave   bus
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_prio;     // 0 = A favoured, 1 = B favoured
  logic                  r_busy;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
  logic                  w_prio_nxt;
  logic                  w_busy_nxt;
  logic                  w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wr_data_nxt;
  logic                  w_run;
  logic                  w_grant_a;
  logic                  w_grant_b;

  // Same-cycle grants; forced low while the clear sequence owns the port.
  always_comb begin
    w_run     = (r_state == S_RUN);
    w_grant_a = w_run && bus.req_a && (!bus.req_b || !r_prio);
    w_grant_b = w_run && bus.req_b && (!bus.req_a ||  r_prio);
  end

  // Next-state and next-output decode for the clear walk and the transfer path.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_prio_nxt    = r_prio;
    w_busy_nxt    = r_busy;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    unique case (r_state)
      S_CLEAR: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_clr_cnt;
        w_wr_data_nxt = '0;
        w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
        if (r_clr_cnt == '1) begin
          w_state_nxt = S_RUN;
          w_busy_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (w_grant_a) begin
          w_wr_en_nxt   = (bus.addr_a != '1);
          w_wr_addr_nxt = bus.addr_a;
          w_wr_data_nxt = bus.data_a;
          w_prio_nxt    = 1'b1;
        end else if (w_grant_b) begin
          w_wr_en_nxt   = (bus.addr_b != '1);
          w_wr_addr_nxt = bus.addr_b;
          w_wr_data_nxt = bus.data_b;
          w_prio_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // State and registered write bus; reset drops any in-flight write at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_prio    <= 1'b0;
      r_busy    <= 1'b1;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_prio    <= w_prio_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  assign bus.grant_a = w_grant_a;
  assign bus.grant_b = w_grant_b;
  assign bus.busy    = r_busy;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset/clear walk, single
// requester, contention, zero-register writes and asynchronous resets.
// Expected writes are queued when a request is driven and checked one
// clock later against the registered write bus.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  int unsigned total = 0;
  int unsigned bad   = 0;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic          m_prio;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic ra, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic rb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    bus.req_a  = ra;
    bus.addr_a = aa;
    bus.data_a = da;
    bus.req_b  = rb;
    bus.addr_b = ab;
    bus.data_b = db;
  endtask

  // Reset values, checked with both requests held high.
  task automatic chk_reset(input string tag);
    set_req(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    #1;
    check({tag, "_wr_en"},   bus.wr_en,   1'b0);
    check({tag, "_wr_addr"}, bus.wr_addr, 5'd0);
    check({tag, "_wr_data"}, bus.wr_data, 32'd0);
    check({tag, "_busy"},    bus.busy,    1'b1);
    check({tag, "_grant_a"}, bus.grant_a, 1'b0);
    check({tag, "_grant_b"}, bus.grant_b, 1'b0);
  endtask

  // Release reset and follow the clear walk; optionally stop early.
  task automatic do_clear(input int unsigned stop_at, input logic hold);
    set_req(hold, 5'd3, 32'h1, hold, 5'd4, 32'h2);
    @(negedge clk);
    reset_n = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      check("clr_wr_en",   bus.wr_en,   1'b1);
      check("clr_wr_addr", bus.wr_addr, AW'(i));
      check("clr_wr_data", bus.wr_data, 32'd0);
      check("clr_busy",    bus.busy,    (i != 31));
      if (i < 31) begin
        check("clr_grant_a", bus.grant_a, 1'b0);
        check("clr_grant_b", bus.grant_b, 1'b0);
      end else if (hold) begin
        check("run0_grant_a", bus.grant_a, 1'b1);
        check("run0_grant_b", bus.grant_b, 1'b0);
      end
      if (i == stop_at) break;
    end
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    m_prio = 1'b0;
    m_addr = '1;
    m_data = '0;
    exp_q.delete();
  endtask

  // One RUN cycle: drive, check grants, queue expected write, check it after the edge.
  task automatic cycle(input logic ra, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic rb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic eg_a, eg_b;
    wr_t  w;
    set_req(ra, aa, da, rb, ab, db);
    #3;
    eg_a = ra && (!rb || !m_prio);
    eg_b = rb && (!ra ||  m_prio);
    check("grant_a", bus.grant_a, eg_a);
    check("grant_b", bus.grant_b, eg_b);
    check("grant_excl", bus.grant_a & bus.grant_b, 1'b0);
    check("run_busy", bus.busy, 1'b0);
    if (eg_a) begin
      m_addr = aa;
      m_data = da;
      m_prio = 1'b1;
      w.en   = (aa != '1);
    end else if (eg_b) begin
      m_addr = ab;
      m_data = db;
      m_prio = 1'b0;
      w.en   = (ab != '1);
    end else begin
      w.en   = 1'b0;
    end
    w.addr = m_addr;
    w.data = m_data;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    check("wr_en",   bus.wr_en,   w.en);
    check("wr_addr", bus.wr_addr, w.addr);
    check("wr_data", bus.wr_data, w.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1;
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    m_prio = 1'b0;
    m_addr = '1;
    m_data = '0;
    #2 reset_n = 1'b0;
    chk_reset("rst0");
    do_clear(99, 1'b1);

    // Single requester A, then idle.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    cycle(1'b0, '0, '0, 1'b0, '0, '0);
    // Zero register write from B: consumed, no write issued, pointer back to A.
    cycle(1'b0, '0, '0, 1'b1, 5'd31, 32'h1234);
    cycle(1'b0, '0, '0, 1'b0, '0, '0);
    // Contention for four cycles: A,B,A,B.
    for (int unsigned k = 0; k < 4; k++)
      cycle(1'b1, AW'(8 + k), 32'hA000 + k, 1'b1, AW'(16 + k), 32'hB000 + k);
    cycle(1'b0, '0, '0, 1'b0, '0, '0);
    // Back-to-back from B alone.
    cycle(1'b0, '0, '0, 1'b1, 5'd20, 32'h5555);
    cycle(1'b0, '0, '0, 1'b1, 5'd21, 32'h6666);
    cycle(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset in the middle of the clear walk.
    reset_n = 1'b0;
    chk_reset("rst1");
    do_clear(10, 1'b0);
    reset_n = 1'b0;
    chk_reset("rst_midclear");
    do_clear(99, 1'b0);

    // Reset while a granted write is on the bus.
    cycle(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, '0, '0);
    reset_n = 1'b0;
    chk_reset("rst_midxfer");
    do_clear(99, 1'b1);
    cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
    cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
    cycle(1'b0, '0, '0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
